// File: rtl/bt_flow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bt_flow_ctrl_pkg
// Description : Shared types, width helper and default watermarks for the
//               Bluetooth UART RTS/CTS flow controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bt_flow_ctrl_pkg;

    localparam int c_DEF_RX_DEPTH    = 16;
    localparam int c_DEF_HIGH_WM     = 12;
    localparam int c_DEF_LOW_WM      = 4;
    localparam int c_DEF_CTS_TIMEOUT = 1000000;
    localparam int c_DEF_CNT_W       = 32;

    typedef enum logic [1:0] {
        TX_HOLD    = 2'd0,
        TX_RUN     = 2'd1,
        TX_TIMEOUT = 2'd2
    } tx_state_t;

    typedef enum logic {
        RTS_OFF = 1'b0,
        RTS_ON  = 1'b1
    } rts_state_t;

    // Level counter needs one extra bit to represent a completely full FIFO.
    function automatic int LVL_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bt_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bt_rx_fifo
// Description : First-word-fall-through RX byte FIFO with occupancy output and
//               a drop indication for writes that arrive while full.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_rx_fifo
    import bt_flow_ctrl_pkg::*;
#(
    parameter int RX_DEPTH = c_DEF_RX_DEPTH
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_wr_valid,
    input  logic [7:0]                  i_wr_data,
    output logic [7:0]                  o_rd_data,
    output logic                        o_rd_valid,
    input  logic                        i_rd_ready,
    output logic [LVL_W(RX_DEPTH)-1:0]  o_level,
    output logic                        o_wr_drop
);

    localparam int c_PTR_W = $clog2(RX_DEPTH);
    localparam int c_LVL_W = LVL_W(RX_DEPTH);

    logic [7:0]         r_mem [RX_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    logic w_full;
    logic w_wr;
    logic w_rd;

    // Full is judged on the pre-update level, so a same-cycle read cannot rescue a write.
    assign w_full     = (r_level == c_LVL_W'(RX_DEPTH));
    assign w_wr       = i_wr_valid && !w_full;
    assign w_rd       = o_rd_valid && i_rd_ready;
    assign o_wr_drop  = i_wr_valid && w_full;
    assign o_rd_valid = (r_level != '0);
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_level    = r_level;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bt_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bt_flow_ctrl
// Description : RTS/CTS flow controller between the Bluetooth UART SerDes and
//               the bt_ctsn/bt_rtsn pins. Optional statistics counters are
//               enabled with the BT_FLOW_CTRL_STATS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_flow_ctrl
    import bt_flow_ctrl_pkg::*;
#(
    parameter int RX_DEPTH    = c_DEF_RX_DEPTH,
    parameter int HIGH_WM     = c_DEF_HIGH_WM,
    parameter int LOW_WM      = c_DEF_LOW_WM,
    parameter int CTS_TIMEOUT = c_DEF_CTS_TIMEOUT,
    parameter int CNT_W       = c_DEF_CNT_W
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      bt_ctsn,
    output logic                      bt_rtsn,
    input  logic [7:0]                s_tx_tdata,
    input  logic                      s_tx_tvalid,
    output logic                      s_tx_tready,
    output logic [7:0]                m_tx_tdata,
    output logic                      m_tx_tvalid,
    input  logic                      m_tx_tready,
    input  logic [7:0]                s_rx_tdata,
    input  logic                      s_rx_tvalid,
    output logic [7:0]                m_rx_tdata,
    output logic                      m_rx_tvalid,
    input  logic                      m_rx_tready,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    output logic                      cts_timeout,
    output logic                      rx_overflow,
`ifdef BT_FLOW_CTRL_STATS_EN
    output logic [CNT_W-1:0]          tx_count,
    output logic [CNT_W-1:0]          rx_count,
    output logic [CNT_W-1:0]          drop_count,
`endif
    input  logic                      clear_flags
);

    localparam int c_LVL_W   = LVL_W(RX_DEPTH);
    localparam int c_STALL_W = $clog2(CTS_TIMEOUT);

    logic                 r_ctsn_meta;
    logic                 r_ctsn_sync;
    tx_state_t            r_tx_state;
    tx_state_t            w_tx_state_nxt;
    logic [c_STALL_W-1:0] r_stall_cnt;
    rts_state_t           r_rts_state;
    rts_state_t           w_rts_state_nxt;
    logic [7:0]           r_m_tx_tdata;
    logic                 r_m_tx_tvalid;
    logic                 r_cts_timeout;
    logic                 r_rx_overflow;
    logic [c_LVL_W-1:0]   w_rx_level;

    logic w_cts_ok;
    logic w_tx_run;
    logic w_tx_to;
    logic w_tx_acc;
    logic w_tx_drop;
    logic w_to_set;
    logic w_rx_drop;

    // ---------------------------------------------------------------- CTS sync
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_ctsn_meta <= 1'b1;
            r_ctsn_sync <= 1'b1;
        end else begin
            r_ctsn_meta <= bt_ctsn;
            r_ctsn_sync <= r_ctsn_meta;
        end
    end

    assign w_cts_ok = !r_ctsn_sync;

    // ------------------------------------------------------------------ TX FSM
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_tx_state <= TX_HOLD;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            TX_HOLD: begin
                if (w_cts_ok) begin
                    w_tx_state_nxt = TX_RUN;
                end else if (s_tx_tvalid && (r_stall_cnt == c_STALL_W'(CTS_TIMEOUT - 1))) begin
                    w_tx_state_nxt = TX_TIMEOUT;
                end
            end
            TX_RUN: begin
                if (!w_cts_ok) begin
                    w_tx_state_nxt = TX_HOLD;
                end
            end
            TX_TIMEOUT: begin
                if (w_cts_ok) begin
                    w_tx_state_nxt = TX_RUN;
                end
            end
            default: w_tx_state_nxt = TX_HOLD;
        endcase
    end

    always_comb begin
        w_tx_run    = (r_tx_state == TX_RUN);
        w_tx_to     = (r_tx_state == TX_TIMEOUT);
        s_tx_tready = w_tx_to || (w_tx_run && (!r_m_tx_tvalid || m_tx_tready));
    end

    // Counter sits at zero outside TX_HOLD, which clears it on every entry.
    always_ff @(posedge aclk) begin
        if (!aresetn || (r_tx_state != TX_HOLD)) begin
            r_stall_cnt <= '0;
        end else if (s_tx_tvalid && !w_cts_ok && (w_tx_state_nxt == TX_HOLD)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign w_tx_acc  = s_tx_tvalid && s_tx_tready && w_tx_run;
    assign w_tx_drop = s_tx_tvalid && w_tx_to;
    assign w_to_set  = (r_tx_state == TX_HOLD) && (w_tx_state_nxt == TX_TIMEOUT);

    // A committed byte stays valid until the serializer takes it, regardless of CTS.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_m_tx_tvalid <= 1'b0;
            r_m_tx_tdata  <= 8'h00;
        end else if (w_tx_acc) begin
            r_m_tx_tvalid <= 1'b1;
            r_m_tx_tdata  <= s_tx_tdata;
        end else if (m_tx_tready) begin
            r_m_tx_tvalid <= 1'b0;
        end
    end

    assign m_tx_tvalid = r_m_tx_tvalid;
    assign m_tx_tdata  = r_m_tx_tdata;

    // ----------------------------------------------------------------- RX FIFO
    bt_rx_fifo #(
        .RX_DEPTH   (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk      (aclk),
        .i_rstn     (aresetn),
        .i_wr_valid (s_rx_tvalid),
        .i_wr_data  (s_rx_tdata),
        .o_rd_data  (m_rx_tdata),
        .o_rd_valid (m_rx_tvalid),
        .i_rd_ready (m_rx_tready),
        .o_level    (w_rx_level),
        .o_wr_drop  (w_rx_drop)
    );

    assign rx_level = w_rx_level;

    // ----------------------------------------------------------------- RTS FSM
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rts_state <= RTS_OFF;
        end else begin
            r_rts_state <= w_rts_state_nxt;
        end
    end

    always_comb begin
        w_rts_state_nxt = r_rts_state;
        case (r_rts_state)
            RTS_OFF: if (w_rx_level <= c_LVL_W'(LOW_WM))  w_rts_state_nxt = RTS_ON;
            RTS_ON:  if (w_rx_level >= c_LVL_W'(HIGH_WM)) w_rts_state_nxt = RTS_OFF;
            default: w_rts_state_nxt = RTS_OFF;
        endcase
    end

    always_comb begin
        bt_rtsn = (r_rts_state != RTS_ON);
    end

    // ------------------------------------------------------------ sticky flags
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cts_timeout <= 1'b0;
            r_rx_overflow <= 1'b0;
        end else begin
            if (w_to_set) begin
                r_cts_timeout <= 1'b1;
            end else if (clear_flags) begin
                r_cts_timeout <= 1'b0;
            end
            if (w_rx_drop) begin
                r_rx_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_rx_overflow <= 1'b0;
            end
        end
    end

    assign cts_timeout = r_cts_timeout;
    assign rx_overflow = r_rx_overflow;

`ifdef BT_FLOW_CTRL_STATS_EN
    // ------------------------------------------------------------- statistics
    logic [CNT_W-1:0] r_tx_count;
    logic [CNT_W-1:0] r_rx_count;
    logic [CNT_W-1:0] r_drop_count;
    logic [CNT_W:0]   w_drop_sum;
    logic [1:0]       w_drop_inc;

    // Timeout discards and overflow drops can coincide, hence a 2-step add.
    assign w_drop_inc = {1'b0, w_tx_drop} + {1'b0, w_rx_drop};
    assign w_drop_sum = {1'b0, r_drop_count} + (CNT_W + 1)'(w_drop_inc);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_tx_count   <= '0;
            r_rx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (r_m_tx_tvalid && m_tx_tready && (r_tx_count != '1)) begin
                r_tx_count <= r_tx_count + 1'b1;
            end
            if (s_rx_tvalid && !w_rx_drop && (r_rx_count != '1)) begin
                r_rx_count <= r_rx_count + 1'b1;
            end
            r_drop_count <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
        end
    end

    assign tx_count   = r_tx_count;
    assign rx_count   = r_rx_count;
    assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: doc/bt_flow_ctrl.md
# bt_flow_ctrl

Hardware RTS/CTS flow controller between the PL-side Bluetooth UART serializer/deserializer and the `bt_ctsn`/`bt_rtsn` module pins. It gates the TX byte stream on the synchronized remote CTS and detects CTS stalls. It buffers received bytes in a small FIFO and drives `bt_rtsn` with watermark hysteresis. One instance sits in the top-level wrapper, alongside the block-design instance.

## Interface
- `RX_DEPTH`, 16: RX FIFO depth in bytes. Power of 2, ≥4.
- `HIGH_WM`, 12: RX level at which RTS is deasserted. Requires `LOW_WM < HIGH_WM <= RX_DEPTH`.
- `LOW_WM`, 4: RX level at which RTS is reasserted.
- `CTS_TIMEOUT`, 1000000: cycles of CTS-blocked pending TX before timeout. Must be ≥2.
- `CNT_W`, 32: statistics counter width.

Ports:
- `aclk`  in  1  sole clock.
- `aresetn`  in  1  synchronous, active-low reset.
- `bt_ctsn`  in  1  remote CTS pin, asynchronous, active-low.
- `bt_rtsn`  out  1  local RTS pin, active-low, registered.
- `s_tx_tdata`/`s_tx_tvalid`/`s_tx_tready`  in/in/out  8/1/1  TX bytes from the host.
- `m_tx_tdata`/`m_tx_tvalid`/`m_tx_tready`  out/out/in  8/1/1  TX bytes to the serializer.
- `s_rx_tdata`/`s_rx_tvalid`  in/in  8/1  received bytes from the deserializer. No backpressure.
- `m_rx_tdata`/`m_rx_tvalid`/`m_rx_tready`  out/out/in  8/1/1  RX bytes to the host.
- `rx_level`  out  $clog2(RX_DEPTH)+1  current FIFO occupancy.
- `cts_timeout`  out  1  sticky flag.
- `rx_overflow`  out  1  sticky flag.
- `clear_flags`  in  1  one-cycle pulse that clears both sticky flags.
- `tx_count`/`rx_count`/`drop_count`  out  CNT_W each  present only with `BT_FLOW_CTRL_STATS_EN`.

## Operation
- CTS synchronizer:
  - 2-FF synchronizer; both stages reset to 1 (deasserted).
  - `cts_ok = !ctsn_sync`.
- TX FSM has states `TX_HOLD` (reset state), `TX_RUN` and `TX_TIMEOUT`.
  - `TX_HOLD -> TX_RUN` when `cts_ok`.
  - `TX_RUN -> TX_HOLD` when `!cts_ok`.
  - `TX_TIMEOUT -> TX_RUN` when `cts_ok`.
  - `TX_HOLD -> TX_TIMEOUT` when the stall counter reaches `CTS_TIMEOUT-1`.
    - The stall counter clears on entry to `TX_HOLD`.
    - It increments only while in `TX_HOLD` with `s_tx_tvalid` high, so an idle link never times out.
    - Entering `TX_TIMEOUT` sets `cts_timeout`.
- TX output register (one entry):
  - `s_tx_tready = TX_RUN && (!m_tx_tvalid || m_tx_tready)`.
  - Accepted bytes load `m_tx_tdata` and set `m_tx_tvalid`.
  - Once `m_tx_tvalid` is set, it holds until `m_tx_tready`, even if CTS drops. The serializer completes a committed byte.
  - In `TX_TIMEOUT`, `s_tx_tready = 1`: bytes are accepted and discarded, and counted in `drop_count`.
- RX FIFO:
  - First-word-fall-through; `m_rx_tvalid = !empty`.
  - A write when `s_rx_tvalid` is high and level < `RX_DEPTH` stores the byte.
  - A write while full drops the byte and sets `rx_overflow`, even if a read happens in the same cycle. The full check uses the pre-update level.
  - A read happens when `m_rx_tvalid && m_rx_tready`.
  - Simultaneous read and write leave the level unchanged.
  - Pointers wrap modulo `RX_DEPTH`.
- RTS FSM has states `RTS_ON` (drives `bt_rtsn=0`) and `RTS_OFF` (drives `bt_rtsn=1`). Reset state is `RTS_OFF`.
  - `RTS_OFF -> RTS_ON` when level ≤ `LOW_WM`.
  - `RTS_ON -> RTS_OFF` when level ≥ `HIGH_WM`.
  - Both compares use the registered level.
- `clear_flags` clears both sticky flags. A set event in the same cycle wins.

## Timing
- Reset values:
  - `bt_rtsn` = 1.
  - `m_tx_tvalid` = 0, `m_tx_tdata` = 0.
  - `m_rx_tvalid` = 0.
  - `rx_level` = 0.
  - Both flags = 0; all counters = 0.
  - `s_tx_tready` = 0 (FSM is in `TX_HOLD`).
- `bt_rtsn` goes low on the 2nd cycle after reset release.
- `bt_ctsn` falling edge to `s_tx_tready` high: 3 cycles (2 sync stages plus the FSM register).
- TX accept to `m_tx_tvalid`: 1 cycle.
- RX write to `m_rx_tvalid`/`rx_level` update: 1 cycle.
- Level crossing a watermark to `bt_rtsn` change: 1 cycle.
- Reset mid-operation:
  - FIFO contents and the TX holding register are discarded.
  - All outputs return to their reset values on the next edge.

## Configuration
- `BT_FLOW_CTRL_STATS_EN` defined:
  - Adds `tx_count` (bytes handed to the serializer).
  - Adds `rx_count` (bytes written to the FIFO).
  - Adds `drop_count` (timeout discards plus overflow drops).
  - All three counters saturate at all-ones and do not wrap.
- Without the macro: the counter ports and logic are absent; flow-control behaviour is identical.

## Structure
- Package `bt_flow_ctrl_pkg` holds:
  - TX state enum `tx_state_t` and RTS state enum `rts_state_t`.
  - `LVL_W` width function.
  - Default watermark constants.
- Sub-module `bt_rx_fifo`: FWFT FIFO with level output, parameterized on `RX_DEPTH`.
- Synchronizer, FSMs, TX register and counters live in `bt_flow_ctrl`.

## Test plan
- Reset, then hold `bt_ctsn=0` and stream bytes 0x00–0x3F with `m_tx_tready=1` -> all 64 bytes appear in order, first `m_tx_tvalid` 1 cycle after first accept, `cts_timeout=0`.
- Raise `bt_ctsn` while `m_tx_tvalid=1`, `m_tx_tready=0` -> byte 0xA5 held stable, then delivered when ready rises; no new accept while CTS high.
- `CTS_TIMEOUT=8`, `bt_ctsn=1`, `s_tx_tvalid=1` constant -> `cts_timeout` sets after 8 stalled cycles, next bytes accepted and dropped (`drop_count` increments), CTS low -> `TX_RUN` 3 cycles later.
- Write 12 RX bytes with `m_rx_tready=0` -> `bt_rtsn` high 1 cycle after level=12; read 8 -> `bt_rtsn` low 1 cycle after level=4.
- Write 17 bytes at `RX_DEPTH=16` with a read on the 17th cycle -> 17th byte dropped, `rx_overflow=1`; `clear_flags` pulse -> flag 0 next cycle.
- Assert `aresetn=0` with FIFO holding 5 bytes -> `rx_level=0`, `m_rx_tvalid=0`, `bt_rtsn=1` next cycle.
